mult_seq_ctrl: RTL and testbench

// Sequencing side of the accumulator-register interface: issues the init / en strobes that a

---
 rtl/mult_seq_ctrl.sv | 103 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential add-shift multiplier controller: drives the init/en strobes of a
// clear-with-init accumulator and produces a 2*WIDTH unsigned product over WIDTH RUN cycles.
module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               acc_init,
    output logic               acc_en
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
        end
    end

    // Strobes and status are pure decodes of registered state, never of start/a/b.
    assign busy     = (state_q == S_INIT) || (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign acc_init = (state_q == S_INIT);
    assign acc_en   = (state_q == S_RUN) && b_q[cnt_q];
    assign product  = product_q;

    assign a_ext = {{WIDTH{1'b0}}, a_q};
    assign sum   = acc_q + (acc_en ? (a_ext << cnt_q) : '0);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                acc_d = sum;
                if (cnt_q == CNT_LAST) begin
                    product_d = sum;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed and randomized checks of mult_seq_ctrl against a cycle-timeline model:
// product = a*b, acc_en follows the captured multiplier bits, done WIDTH+1 edges after acceptance.
module tb_mult_seq_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a_i = '0;
    logic [W-1:0]   b_i = '0;
    logic           busy, done, acc_init, acc_en;
    logic [2*W-1:0] product;

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_prod = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a_i),
        .b        (b_i),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .acc_init (acc_init),
        .acc_en   (acc_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered with clk low; returns at the negedge of the first IDLE cycle after DONE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                          input string nm);
        start = 1'b1;
        a_i   = a;
        b_i   = b;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int j = 0; j <= W + 2; j++) begin
            a_i = W'($urandom);
            b_i = W'($urandom);
            @(negedge clk);
            if (j == W + 1) exp_prod = 32'(a) * 32'(b);
            chk($sformatf("%s.busy[%0d]", nm, j), 32'(busy), 32'(j <= W));
            chk($sformatf("%s.done[%0d]", nm, j), 32'(done), 32'(j == W + 1));
            chk($sformatf("%s.acc_init[%0d]", nm, j), 32'(acc_init), 32'(j == 0));
            chk($sformatf("%s.acc_en[%0d]", nm, j), 32'(acc_en),
                (j >= 1 && j <= W) ? 32'(b[j-1]) : 32'd0);
            chk($sformatf("%s.product[%0d]", nm, j), 32'(product), exp_prod);
            if (j < W + 2) @(posedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.acc_init", 32'(acc_init), 32'd0);
        chk("reset.acc_en", 32'(acc_en), 32'd0);
        chk("reset.product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'd13, 8'd11, 1'b0, "t13x11");
        run_op(8'd255, 8'd255, 1'b0, "t255x255");
        run_op(8'd200, 8'd0, 1'b0, "t200x0");

        for (int i = 0; i < 6; i++)
            run_op(W'($urandom), W'($urandom), 1'b0, $sformatf("rnd%0d", i));

        for (int i = 0; i < 3; i++)
            run_op(W'($urandom), W'($urandom), 1'b1, $sformatf("hold%0d", i));
        start = 1'b0;
        @(negedge clk);
        chk("hold.idle_busy", 32'(busy), 32'd0);

        // Abort in RUN cycle 4 (cnt=4).
        start = 1'b1;
        a_i   = 8'd77;
        b_i   = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort.pre_busy", 32'(busy), 32'd1);
        chk("abort.pre_acc_en", 32'(acc_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        exp_prod = 0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.acc_init", 32'(acc_init), 32'd0);
        chk("abort.acc_en", 32'(acc_en), 32'd0);
        chk("abort.product", 32'(product), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("abort.nodone[%0d]", i), 32'(done), 32'd0);
            chk($sformatf("abort.idle_busy[%0d]", i), 32'(busy), 32'd0);
        end

        run_op(8'd13, 8'd11, 1'b0, "post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
